// File: rtl/w_norm_sequencer.sv
// Sequencer for the final FastICA W-vector normalisation: one norm request, then SIZE_N divisions.
// Optional macro W_NORM_ZERO_GUARD_EN skips the divisions and flags norm_zero when the norm is +/-0.0.
//
// state       | meaning
// ------------+-----------------------------------------------
// S_IDLE      | waiting for start; w_out holds the last result
// S_NORM_REQ  | norm_start pulse to the Frobenius-norm unit
// S_NORM_WAIT | waiting for norm_valid
// S_DIV_ISSUE | div_start pulse for element idx
// S_DIV_WAIT  | waiting for div_valid for element idx
// S_DONE      | valid pulse, back to idle
module w_norm_sequencer #(
  parameter int SIZE_N = 8,
  parameter int IDX_W  = $clog2(SIZE_N)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] w_in [SIZE_N],
  output logic        norm_start,
  output logic [63:0] norm_vec [SIZE_N],
  input  logic        norm_valid,
  input  logic [63:0] norm_result,
  output logic        div_start,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  input  logic        div_valid,
  input  logic [63:0] div_result,
  output logic [63:0] w_out [SIZE_N],
  output logic        busy,
  output logic        valid
`ifdef W_NORM_ZERO_GUARD_EN
  ,
  output logic        norm_zero
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_NORM_REQ, S_NORM_WAIT, S_DIV_ISSUE, S_DIV_WAIT, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE_N - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [63:0]      w_reg [SIZE_N];
  logic [63:0]      norm_reg;
`ifdef W_NORM_ZERO_GUARD_EN
  logic             zero_skip;
`endif

  assign norm_vec = w_reg;
  assign div_b    = norm_reg;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
`ifdef W_NORM_ZERO_GUARD_EN
    zero_skip = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_NORM_REQ;
          idx_nxt   = '0;
        end
      end
      S_NORM_REQ:  state_nxt = S_NORM_WAIT;
      S_NORM_WAIT: begin
        if (norm_valid) begin
          state_nxt = S_DIV_ISSUE;
`ifdef W_NORM_ZERO_GUARD_EN
          // sign bit ignored: both +0.0 and -0.0 take the bypass
          if (norm_result[62:0] == 63'd0) begin
            zero_skip = 1'b1;
            state_nxt = S_DONE;
          end
`endif
        end
      end
      S_DIV_ISSUE: state_nxt = S_DIV_WAIT;
      S_DIV_WAIT: begin
        if (div_valid) begin
          if (idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_DIV_ISSUE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      norm_reg   <= '0;
      div_a      <= '0;
      norm_start <= 1'b0;
      div_start  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      for (int i = 0; i < SIZE_N; i++) begin
        w_reg[i] <= '0;
        w_out[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      norm_start <= (state_nxt == S_NORM_REQ);
      div_start  <= (state_nxt == S_DIV_ISSUE);
      busy       <= (state_nxt != S_IDLE);
      valid      <= (state_nxt == S_DONE);
      if (state == S_IDLE && start) w_reg <= w_in;
      if (state == S_NORM_WAIT && norm_valid) norm_reg <= norm_result;
      if (state_nxt == S_DIV_ISSUE) div_a <= w_reg[idx_nxt];
      if (state == S_DIV_WAIT && div_valid) w_out[idx] <= div_result;
`ifdef W_NORM_ZERO_GUARD_EN
      if (zero_skip) w_out <= w_reg;
`endif
    end
  end

`ifdef W_NORM_ZERO_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) norm_zero <= 1'b0;
    else      norm_zero <= zero_skip;
  end
`endif

endmodule

// File: tb/tb_w_norm_sequencer.sv
// Bench for w_norm_sequencer: table-driven runs, hand-written corner sequences and random runs
// against a real-arithmetic model; the norm and divider units are modelled with fixed latencies.
module tb_w_norm_sequencer;
  localparam int N = 8;
  typedef logic [63:0] dbl_t;

  typedef struct packed {
    logic [N-1:0][63:0] v;
    logic [N-1:0][63:0] ew;
    logic [63:0]        nrm;
    logic [7:0]         tn;
    logic [7:0]         td;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, norm_start, norm_valid, div_start, div_valid, busy, valid;
  dbl_t w_in [N];
  dbl_t norm_vec [N];
  dbl_t w_out [N];
  dbl_t norm_result, div_a, div_b, div_result;
`ifdef W_NORM_ZERO_GUARD_EN
  logic norm_zero;
`endif

  w_norm_sequencer #(.SIZE_N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in),
    .norm_start(norm_start), .norm_vec(norm_vec), .norm_valid(norm_valid),
    .norm_result(norm_result), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_valid(div_valid), .div_result(div_result), .w_out(w_out), .busy(busy),
    .valid(valid)
`ifdef W_NORM_ZERO_GUARD_EN
    , .norm_zero(norm_zero)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  dbl_t cur_v [N];
  dbl_t exp_w [N];
  dbl_t unit_norm;
  int lat, nns, ndiv, nv, nz_all;
  vec_t tbl [4];

  task automatic check64(input string nm, input dbl_t act, input dbl_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0][63:0] pk(input real a0, a1, a2, a3, a4, a5, a6, a7);
    logic [N-1:0][63:0] r;
    r[0] = $realtobits(a0); r[1] = $realtobits(a1); r[2] = $realtobits(a2); r[3] = $realtobits(a3);
    r[4] = $realtobits(a4); r[5] = $realtobits(a5); r[6] = $realtobits(a6); r[7] = $realtobits(a7);
    return r;
  endfunction

  function automatic vec_t mk(input logic [N-1:0][63:0] v, ew, input real nrm, input int tn, td);
    vec_t r;
    r.v = v; r.ew = ew; r.nrm = $realtobits(nrm); r.tn = 8'(tn); r.td = 8'(td);
    return r;
  endfunction

  task automatic load_row(input int k);
    for (int i = 0; i < N; i++) begin
      cur_v[i] = tbl[k].v[i];
      exp_w[i] = tbl[k].ew[i];
    end
    unit_norm = tbl[k].nrm;
  endtask

  // Reference: Euclidean norm and element-wise quotient in plain real arithmetic.
  task automatic model_set();
    real s, x, nrm;
    s = 0.0;
    for (int i = 0; i < N; i++) begin
      x = $bitstoreal(cur_v[i]);
      s = s + x * x;
    end
    nrm = $sqrt(s);
    unit_norm = $realtobits(nrm);
    for (int i = 0; i < N; i++) exp_w[i] = $realtobits($bitstoreal(cur_v[i]) / nrm);
  endtask

  function automatic int exp_lat(input int tn, td, stall);
    return 2 + tn + N * (1 + td) + 1 + stall;
  endfunction

  task automatic run(input int tn, td, stall_idx, stall_len, mid_start, abort_div,
                     input bit spur, zero_norm, b2b);
    int c0, pend_n, pend_d;
    bit done, abort_pend;
    dbl_t cap_a, cap_b;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < N; i++) w_in[i] = cur_v[i];
    c0 = cyc; pend_n = -1; pend_d = -1; done = 1'b0; abort_pend = 1'b0;
    cap_a = '0; cap_b = '0;
    lat = -1; nns = 0; ndiv = 0; nv = 0; nz_all = 0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(posedge clk); #1;
      start = 1'b0; norm_valid = 1'b0; div_valid = 1'b0;
      if (abort_pend) begin
        rst = 1'b0; #1;
        checki("rst_busy", busy, 0); checki("rst_valid", valid, 0);
        checki("rst_norm_start", norm_start, 0); checki("rst_div_start", div_start, 0);
        check64("rst_div_a", div_a, '0); check64("rst_div_b", div_b, '0);
        for (int i = 0; i < N; i++) begin
          check64($sformatf("rst_w_out%0d", i), w_out[i], '0);
          check64($sformatf("rst_norm_vec%0d", i), norm_vec[i], '0);
        end
`ifdef W_NORM_ZERO_GUARD_EN
        checki("rst_norm_zero", norm_zero, 0);
`endif
        done = 1'b1;
      end else begin
        if (t == 0) begin
          for (int i = 0; i < N; i++) w_in[i] = ~cur_v[i];
          checki("req_busy", busy, 1); checki("req_norm_start", norm_start, 1);
        end
        if (norm_start) begin nns++; pend_n = cyc + tn; end
        if (pend_d >= 0) begin
          check64("div_a_hold", div_a, cap_a); check64("div_b_hold", div_b, cap_b);
          checki("div_start_quiet", div_start, 0);
        end else if (div_start) begin
          ndiv++; cap_a = div_a; cap_b = div_b;
          if (ndiv <= N) check64($sformatf("div_a_idx%0d", ndiv - 1), div_a, cur_v[ndiv - 1]);
          check64("div_b_norm", div_b, unit_norm);
          pend_d = cyc + td + ((ndiv - 1 == stall_idx) ? stall_len : 0);
          if (spur) begin
            div_valid = 1'b1; div_result = 64'hDEAD_BEEF_0BAD_F00D;
            norm_valid = 1'b1; norm_result = $realtobits(123.0);
          end
          if (abort_div == ndiv - 1) abort_pend = 1'b1;
        end
        if (pend_n == cyc) begin
          norm_valid = 1'b1;
          norm_result = zero_norm ? 64'h8000_0000_0000_0000 : unit_norm;
          pend_n = -1;
        end
        if (pend_d == cyc) begin
          div_valid = 1'b1;
          div_result = $realtobits($bitstoreal(cap_a) / $bitstoreal(cap_b));
          pend_d = -1;
        end
        if (mid_start >= 0 && cyc - c0 == mid_start) start = 1'b1;
`ifdef W_NORM_ZERO_GUARD_EN
        if (norm_zero) nz_all++;
`endif
        if (valid) begin
          nv++;
          lat = cyc - c0 + 1;
          checki("valid_busy", busy, 1);
`ifdef W_NORM_ZERO_GUARD_EN
          checki("norm_zero_with_valid", norm_zero, int'(zero_norm));
`endif
          if (b2b) begin
            start = 1'b1;
            for (int i = 0; i < N; i++) w_in[i] = ~cur_v[i];
          end
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: no valid within cycle bound");
    end
  endtask

  task automatic check_run(input string tag, input int elat, edivs, enz);
    checki({tag, "_latency"}, lat, elat);
    checki({tag, "_norm_starts"}, nns, 1);
    checki({tag, "_div_starts"}, ndiv, edivs);
    checki({tag, "_valids"}, nv, 1);
`ifdef W_NORM_ZERO_GUARD_EN
    checki({tag, "_norm_zero"}, nz_all, enz);
`else
    if (enz != 0) $display("note: norm_zero not built");
`endif
    for (int i = 0; i < N; i++) check64($sformatf("%s_w_out%0d", tag, i), w_out[i], exp_w[i]);
  endtask

  task automatic post_idle();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checki("post_valid", valid, 0); checki("post_busy", busy, 0);
`ifdef W_NORM_ZERO_GUARD_EN
      checki("post_norm_zero", norm_zero, 0);
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(pk(3, 4, 0, 0, 0, 0, 0, 0), pk(0.6, 0.8, 0, 0, 0, 0, 0, 0), 5.0, 4, 3);
    tbl[1] = mk(pk(1, 1, 1, 1, 0, 0, 0, 0), pk(0.5, 0.5, 0.5, 0.5, 0, 0, 0, 0), 2.0, 1, 1);
    tbl[2] = mk(pk(0, -6, 0, 0, 0, 0, 0, 8), pk(0, -0.6, 0, 0, 0, 0, 0, 0.8), 10.0, 2, 2);
    tbl[3] = mk(pk(0, 0, 0, 0, 0, 2, 1, 2), pk(0, 0, 0, 0, 0, 2.0/3.0, 1.0/3.0, 2.0/3.0), 3.0, 3, 1);

    rst = 1'b0; start = 1'b0; norm_valid = 1'b0; div_valid = 1'b0;
    norm_result = '0; div_result = '0;
    for (int i = 0; i < N; i++) w_in[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checki("reset_busy", busy, 0); checki("reset_valid", valid, 0);
    checki("reset_norm_start", norm_start, 0); checki("reset_div_start", div_start, 0);
    check64("reset_div_b", div_b, '0);
    for (int i = 0; i < N; i++) check64($sformatf("reset_w_out%0d", i), w_out[i], '0);
    @(posedge clk); #1 rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      load_row(k);
      run(int'(tbl[k].tn), int'(tbl[k].td), -1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
      check_run($sformatf("row%0d", k), exp_lat(int'(tbl[k].tn), int'(tbl[k].td), 0), N, 0);
      post_idle();
    end

    // divider stalls 20 cycles on element 5
    load_row(0);
    run(4, 3, 5, 17, -1, -1, 1'b0, 1'b0, 1'b0);
    check_run("stall", exp_lat(4, 3, 17), N, 0);
    post_idle();

    // start mid-run plus spurious unit pulses during DIV_ISSUE
    load_row(3);
    run(3, 1, -1, 0, 10, -1, 1'b1, 1'b0, 1'b0);
    check_run("midstart", exp_lat(3, 1, 0), N, 0);
    post_idle();

    // spurious unit pulses in IDLE
    @(posedge clk); #1;
    norm_valid = 1'b1; norm_result = $realtobits(7.0);
    div_valid = 1'b1; div_result = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    norm_valid = 1'b0; div_valid = 1'b0;
    @(posedge clk); #1;
    checki("idle_spur_busy", busy, 0); checki("idle_spur_norm_start", norm_start, 0);
    for (int i = 0; i < N; i++) check64($sformatf("idle_spur_w_out%0d", i), w_out[i], exp_w[i]);

    // back-to-back: start in the valid cycle is ignored, next cycle accepted
    load_row(1);
    run(1, 1, -1, 0, -1, -1, 1'b0, 1'b0, 1'b1);
    check_run("b2b_a", exp_lat(1, 1, 0), N, 0);
    load_row(2);
    run(2, 2, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check_run("b2b_b", exp_lat(2, 2, 0), N, 0);
    post_idle();

    // reset in DIV_WAIT at idx 3, late div_valid, then a full run
    load_row(0);
    run(2, 3, -1, 0, -1, 3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b1; div_result = $realtobits(9.0);
    @(posedge clk); #1;
    div_valid = 1'b0;
    checki("late_div_busy", busy, 0);
    for (int i = 0; i < N; i++) check64($sformatf("late_div_w_out%0d", i), w_out[i], '0);
    run(2, 3, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check_run("after_rst", exp_lat(2, 3, 0), N, 0);
    post_idle();

`ifdef W_NORM_ZERO_GUARD_EN
    load_row(0);
    for (int i = 0; i < N; i++) exp_w[i] = cur_v[i];
    run(4, 3, -1, 0, -1, -1, 1'b0, 1'b1, 1'b0);
    check_run("zero_norm", 2 + 4 + 1, 0, 1);
    post_idle();
`endif

    for (int r = 0; r < 6; r++) begin
      int tn, td, sidx, slen;
      cur_v[0] = $realtobits($itor($urandom_range(1, 1000)) / 8.0);
      for (int i = 1; i < N; i++)
        cur_v[i] = $realtobits(($itor($urandom_range(0, 2000)) - 1000.0) / 8.0);
      model_set();
      tn = $urandom_range(1, 5);
      td = $urandom_range(1, 4);
      sidx = (r % 2 == 1) ? int'($urandom_range(0, N - 1)) : -1;
      slen = (sidx >= 0) ? int'($urandom_range(1, 12)) : 0;
      run(tn, td, sidx, slen, -1, -1, 1'b0, 1'b0, 1'b0);
      check_run($sformatf("rand%0d", r), exp_lat(tn, td, slen), N, 0);
      post_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/w_norm_sequencer.md
# w_norm_sequencer

Controller that sequences the final W-vector normalisation stage of the FastICA datapath. It latches one `SIZE_N`-element double-precision weight vector and issues it once to the shared Frobenius-norm unit. It then streams each element through the shared scalar divider, dividing by that norm. The normalised vector is presented with a one-cycle `valid` pulse. It sits between the W-update stage and the convergence check, and owns the start/valid handshakes of both arithmetic units.

## Interface
- `SIZE_N`, 8, vector length (≥2)
- `IDX_W`, `$clog2(SIZE_N)`, element index width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: run request, sampled only in IDLE
- `w_in[SIZE_N][1]` in double: input vector, sampled on the accepted `start`
- `norm_start` out 1: one-cycle request to the norm unit
- `norm_vec[SIZE_N][1]` out double: latched vector, stable while `busy`
- `norm_valid` in 1: norm result ready
- `norm_result` in double: Frobenius norm
- `div_start` out 1: one-cycle request to the divider
- `div_a` out double: dividend, i.e. `w_reg[idx]`; stable from DIV_ISSUE until `div_valid`
- `div_b` out double: divisor, i.e. latched norm
- `div_valid` in 1: quotient ready
- `div_result` in double: quotient
- `w_out[SIZE_N][1]` out double: normalised vector
- `busy` out 1: high in every state except IDLE
- `valid` out 1: one-cycle completion pulse
- `norm_zero` out 1: exists only with `W_NORM_ZERO_GUARD_EN`

`double` is the 64-bit type from `fp_double`. All outputs are registered.

## Operation
- FSM states: IDLE, NORM_REQ, NORM_WAIT, DIV_ISSUE, DIV_WAIT, DONE.
- IDLE
  - On `start`: latch `w_in` into `w_reg`, clear `idx`, go to NORM_REQ.
  - `start` in any other state is ignored. It is not queued.
- NORM_REQ: `norm_start`=1 for this cycle only; go to NORM_WAIT.
- NORM_WAIT
  - Wait for `norm_valid`. No timeout.
  - On `norm_valid`: latch `norm_result` into `norm_reg`, go to DIV_ISSUE.
  - `norm_valid` outside NORM_WAIT is ignored.
- DIV_ISSUE: `div_start`=1 for one cycle; `div_a`=`w_reg[idx]`, `div_b`=`norm_reg`; go to DIV_WAIT.
- DIV_WAIT: on `div_valid`, write `w_out[idx]` ← `div_result`.
  - If `idx`==`SIZE_N-1`: go to DONE.
  - Else: `idx`++ and go to DIV_ISSUE.
  - `div_valid` outside DIV_WAIT is ignored.
- DONE: `valid`=1 for one cycle; go to IDLE. `busy` falls in the same cycle the FSM returns to IDLE.
- `w_out` holds the last result until it is overwritten element by element during the next run. Partially updated `w_out` during a run is not valid.
- `idx` never exceeds `SIZE_N-1`; there is no wrap-around.
- Reset (asynchronous, any state)
  - FSM returns to IDLE; `idx`, `w_reg`, `norm_reg`, `w_out` ← 0.
  - `norm_start`, `div_start`, `busy`, `valid`, `norm_zero` ← 0.
  - Any in-flight unit result after reset is ignored.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycle 1: NORM_REQ; `busy`=1 and `norm_start`=1.
- Tn = cycles from `norm_start` to `norm_valid`. Td = cycles from `div_start` to `div_valid`. Both are ≥1.
- Total latency from `start` to `valid` = 2 + Tn + SIZE_N·(1+Td) + 1 cycles.
  - Example: SIZE_N=8, Tn=4, Td=3 → 39 cycles.
- A new `start` may be accepted the cycle after `valid`.
- `start` asserted in the same cycle as `valid` is ignored.

## Configuration
- `W_NORM_ZERO_GUARD_EN` defined
  - In NORM_WAIT, if `norm_result` has zero exponent and zero mantissa (±0.0), skip all divisions.
  - Copy `w_reg` to `w_out`, go to DONE, and pulse `norm_zero` together with `valid`.
  - Latency in this case: 2 + Tn + 1.
- Not defined
  - The `norm_zero` port is absent.
  - A zero norm is divided normally; `w_out` carries whatever the divider produces (Inf/NaN).

## Test plan
- `w_in`=[3,4,0,0,0,0,0,0], Tn=4, Td=3
  - Norm model returns 5.0.
  - `w_out`=[0.6,0.8,0,…,0].
  - `valid` exactly one cycle, 39 cycles after `start`; `norm_start` once; `div_start` 8 times.
- Second `start` pulsed mid-run
  - Ignored; exactly one `valid`.
  - Back-to-back run accepted the cycle after `valid`.
- Divider stalls 20 cycles on element 5
  - `div_a`/`div_b` stable throughout the stall.
  - No other `div_start` issued.
  - Final `w_out` correct.
- Spurious `div_valid`/`norm_valid` pulses in IDLE and DIV_ISSUE
  - No state change; no `w_out` write.
- `rst` low during DIV_WAIT at `idx`=3
  - All outputs 0 immediately, FSM in IDLE.
  - A late `div_valid` is ignored.
  - The next `start` completes a full run.
- With `W_NORM_ZERO_GUARD_EN`, `norm_result`=-0.0
  - No `div_start`; `w_out`=`w_in`.
  - `norm_zero`=`valid`=1 for one cycle, 7 cycles after `start` (Tn=4).
